// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback
// stepping, shared memory port handshake, memory watchdog and retire counter.
module rv_multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [9:0]       CODE,
    input  logic [2:0]       INSN_F3,
    input  logic             BR_TAKEN,
    input  logic             MEM_ACK,
    output logic             IR_WE,
    output logic             PC_WE,
    output logic             PC_SEL,
    output logic             ADDR_SEL,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic             RF_WE,
    output logic [2:0]       ALU_F3,
    output logic             TRAP,
    output logic [CNT_W-1:0] RETIRED
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              run;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic [2:0]        alu_f3_q;
    logic              trap_q, trap_set;
    logic              retire;
    logic [CNT_W-1:0]  retired_q;
    logic              code_ok;
    logic              force_add;

    assign code_ok   = (CODE != 10'd0) && ((CODE & (CODE - 10'd1)) == 10'd0) && !CODE[9];
    assign force_add = CODE[0] | CODE[1] | CODE[3] | CODE[4] | CODE[6] | CODE[8];

    assign ALU_F3  = alu_f3_q;
    assign TRAP    = trap_q;
    assign RETIRED = retired_q;

    // run stays low through reset so no enable leaks out before the first edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= FETCH;
            run       <= 1'b0;
            wd        <= '0;
            alu_f3_q  <= 3'd0;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            wd    <= wd_nxt;
            if (trap_set)
                trap_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
            if (run && state == DECODE)
                alu_f3_q <= force_add ? 3'd0 : INSN_F3;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_nxt    = '0;
        trap_set  = 1'b0;
        retire    = 1'b0;
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PC_SEL    = 1'b0;
        ADDR_SEL  = 1'b0;
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        RF_WE     = 1'b0;
        if (run) begin
            case (state)
                FETCH: begin
                    MEM_REQ = 1'b1;
                    if (MEM_ACK) begin
                        IR_WE     = 1'b1;
                        state_nxt = DECODE;
                    end else if (wd == WD_LAST) begin
                        trap_set  = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        wd_nxt = wd + WD_W'(1);
                    end
                end
                DECODE: begin
                    if (code_ok) begin
                        state_nxt = EXECUTE;
                    end else begin
                        trap_set  = 1'b1;
                        state_nxt = HALT;
                    end
                end
                EXECUTE: begin
                    if (CODE[6] || CODE[8]) begin
                        state_nxt = MEM;
                    end else if (CODE[5]) begin
                        PC_WE     = 1'b1;
                        PC_SEL    = BR_TAKEN;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end
                MEM: begin
                    MEM_REQ  = 1'b1;
                    ADDR_SEL = 1'b1;
                    MEM_WE   = CODE[8];
                    if (MEM_ACK) begin
                        if (CODE[8]) begin
                            PC_WE     = 1'b1;
                            retire    = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = WB;
                        end
                    end else if (wd == WD_LAST) begin
                        trap_set  = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        wd_nxt = wd + WD_W'(1);
                    end
                end
                WB: begin
                    RF_WE     = 1'b1;
                    PC_WE     = 1'b1;
                    PC_SEL    = CODE[3] | CODE[4];
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Directed bench for rv_multicycle_sequencer: per-cycle vector table plus
// hand-written reset, wrap, fault and watchdog sequences.
module tb_rv_multicycle_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [9:0] CODE;
    logic [2:0] INSN_F3;
    logic       BR_TAKEN;
    logic       MEM_ACK;
    logic       IR_WE, PC_WE, PC_SEL, ADDR_SEL, MEM_REQ, MEM_WE, RF_WE, TRAP;
    logic [2:0] ALU_F3;
    logic [3:0] RETIRED;

    always #5 CLK = ~CLK;

    rv_multicycle_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .CODE(CODE), .INSN_F3(INSN_F3),
        .BR_TAKEN(BR_TAKEN), .MEM_ACK(MEM_ACK), .IR_WE(IR_WE), .PC_WE(PC_WE),
        .PC_SEL(PC_SEL), .ADDR_SEL(ADDR_SEL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .RF_WE(RF_WE), .ALU_F3(ALU_F3), .TRAP(TRAP), .RETIRED(RETIRED)
    );

    // {ir_we, pc_we, pc_sel, addr_sel, mem_req, mem_we, rf_we, alu_f3, trap, retired}
    logic [14:0] obs;
    assign obs = {IR_WE, PC_WE, PC_SEL, ADDR_SEL, MEM_REQ, MEM_WE, RF_WE, ALU_F3, TRAP, RETIRED};

    typedef struct {
        logic [9:0]  code;
        logic [2:0]  f3;
        logic        br;
        logic        ack;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [14:0] ex(input logic ir, input logic pw, input logic ps,
                                       input logic as, input logic rq, input logic mw,
                                       input logic rf, input logic [2:0] alu,
                                       input logic tr, input logic [3:0] rt);
        return {ir, pw, ps, as, rq, mw, rf, alu, tr, rt};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b (ir pw ps as rq mw rf alu3 tr ret4)", name, obs, exp);
    endtask

    task automatic cyc(input logic [9:0] c, input logic [2:0] f, input logic br, input logic ack);
        @(negedge CLK);
        CODE     = c;
        INSN_F3  = f;
        BR_TAKEN = br;
        MEM_ACK  = ack;
        #1;
    endtask

    task automatic add(input logic [9:0] c, input logic [2:0] f, input logic br,
                       input logic ack, input logic [14:0] exp);
        vec_t v;
        v.code = c;
        v.f3   = f;
        v.br   = br;
        v.ack  = ack;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("reset_pulse", ex(0,0,0,0,0,0,0,3'd0,0,4'd0));
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Enters with the next cycle in DECODE carrying an illegal class
    task automatic fault(input logic [9:0] c);
        cyc(c, 3'd0, 1'b0, 1'b0);
        check($sformatf("fault_decode_%03h", c), ex(0,0,0,0,0,0,0,3'd0,0,4'd0));
        cyc(c, 3'd0, 1'b0, 1'b1);
        check($sformatf("fault_halt_%03h", c), ex(0,0,0,0,0,0,0,3'd0,1,4'd0));
        cyc(c, 3'd0, 1'b0, 1'b1);
        check($sformatf("fault_stay_%03h", c), ex(0,0,0,0,0,0,0,3'd0,1,4'd0));
    endtask

    initial begin
        RST_N = 1'b0; CODE = '0; INSN_F3 = '0; BR_TAKEN = 1'b0; MEM_ACK = 1'b0;

        // ALU op 0x080 f3=110
        add(10'h080, 3'd6, 0, 1, ex(1,0,0,0,1,0,0,3'd0,0,4'd0));
        add(10'h080, 3'd6, 0, 0, ex(0,0,0,0,0,0,0,3'd0,0,4'd0));
        add(10'h080, 3'd6, 0, 0, ex(0,0,0,0,0,0,0,3'd6,0,4'd0));
        add(10'h080, 3'd6, 0, 0, ex(0,1,0,0,0,0,1,3'd6,0,4'd0));
        // branch taken
        add(10'h020, 3'd5, 1, 1, ex(1,0,0,0,1,0,0,3'd6,0,4'd1));
        add(10'h020, 3'd5, 1, 0, ex(0,0,0,0,0,0,0,3'd6,0,4'd1));
        add(10'h020, 3'd5, 1, 0, ex(0,1,1,0,0,0,0,3'd5,0,4'd1));
        // branch not taken
        add(10'h020, 3'd4, 0, 1, ex(1,0,0,0,1,0,0,3'd5,0,4'd2));
        add(10'h020, 3'd4, 0, 0, ex(0,0,0,0,0,0,0,3'd5,0,4'd2));
        add(10'h020, 3'd4, 0, 0, ex(0,1,0,0,0,0,0,3'd4,0,4'd2));
        // store
        add(10'h100, 3'd1, 0, 1, ex(1,0,0,0,1,0,0,3'd4,0,4'd3));
        add(10'h100, 3'd1, 0, 0, ex(0,0,0,0,0,0,0,3'd4,0,4'd3));
        add(10'h100, 3'd1, 0, 0, ex(0,0,0,0,0,0,0,3'd0,0,4'd3));
        add(10'h100, 3'd1, 0, 1, ex(0,1,0,1,1,1,0,3'd0,0,4'd3));
        // OP-IMM: one fetch wait, stray ACKs outside FETCH/MEM
        add(10'h004, 3'd3, 0, 0, ex(0,0,0,0,1,0,0,3'd0,0,4'd4));
        add(10'h004, 3'd3, 0, 1, ex(1,0,0,0,1,0,0,3'd0,0,4'd4));
        add(10'h004, 3'd3, 0, 1, ex(0,0,0,0,0,0,0,3'd0,0,4'd4));
        add(10'h004, 3'd3, 0, 1, ex(0,0,0,0,0,0,0,3'd3,0,4'd4));
        add(10'h004, 3'd3, 0, 1, ex(0,1,0,0,0,0,1,3'd3,0,4'd4));
        // load with 3 wait cycles
        add(10'h040, 3'd2, 0, 1, ex(1,0,0,0,1,0,0,3'd3,0,4'd5));
        add(10'h040, 3'd2, 0, 0, ex(0,0,0,0,0,0,0,3'd3,0,4'd5));
        add(10'h040, 3'd2, 0, 0, ex(0,0,0,0,0,0,0,3'd0,0,4'd5));
        add(10'h040, 3'd2, 0, 0, ex(0,0,0,1,1,0,0,3'd0,0,4'd5));
        add(10'h040, 3'd2, 0, 0, ex(0,0,0,1,1,0,0,3'd0,0,4'd5));
        add(10'h040, 3'd2, 0, 0, ex(0,0,0,1,1,0,0,3'd0,0,4'd5));
        add(10'h040, 3'd2, 0, 1, ex(0,0,0,1,1,0,0,3'd0,0,4'd5));
        add(10'h040, 3'd2, 0, 0, ex(0,1,0,0,0,0,1,3'd0,0,4'd5));
        // OP f3=111
        add(10'h080, 3'd7, 0, 1, ex(1,0,0,0,1,0,0,3'd0,0,4'd6));
        add(10'h080, 3'd7, 0, 0, ex(0,0,0,0,0,0,0,3'd0,0,4'd6));
        add(10'h080, 3'd7, 0, 0, ex(0,0,0,0,0,0,0,3'd7,0,4'd6));
        add(10'h080, 3'd7, 0, 0, ex(0,1,0,0,0,0,1,3'd7,0,4'd6));
        // JAL
        add(10'h008, 3'd5, 0, 1, ex(1,0,0,0,1,0,0,3'd7,0,4'd7));
        add(10'h008, 3'd5, 0, 0, ex(0,0,0,0,0,0,0,3'd7,0,4'd7));
        add(10'h008, 3'd5, 0, 0, ex(0,0,0,0,0,0,0,3'd0,0,4'd7));
        add(10'h008, 3'd5, 0, 0, ex(0,1,1,0,0,0,1,3'd0,0,4'd7));

        repeat (2) @(negedge CLK);
        #1;
        check("reset_state", ex(0,0,0,0,0,0,0,3'd0,0,4'd0));
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].code, vecs[i].f3, vecs[i].br, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // eight more ALU ops take the 4-bit counter from 8 through 15 to 0
        for (int i = 0; i < 8; i++) begin
            cyc(10'h080, 3'd6, 0, 1);
            check($sformatf("wrap_fetch%0d", i), ex(1,0,0,0,1,0,0, (i == 0) ? 3'd0 : 3'd6, 0, 4'((8 + i) % 16)));
            cyc(10'h080, 3'd6, 0, 0);
            cyc(10'h080, 3'd6, 0, 0);
            cyc(10'h080, 3'd6, 0, 0);
        end
        cyc(10'h080, 3'd6, 0, 1);
        check("wrap_zero", ex(1,0,0,0,1,0,0,3'd6,0,4'd0));
        cyc(10'h080, 3'd6, 0, 0);
        cyc(10'h080, 3'd6, 0, 0);
        cyc(10'h080, 3'd6, 0, 0);

        // async reset while a load waits on the memory port
        cyc(10'h040, 3'd2, 0, 1);
        check("mid_fetch", ex(1,0,0,0,1,0,0,3'd6,0,4'd1));
        cyc(10'h040, 3'd2, 0, 0);
        cyc(10'h040, 3'd2, 0, 0);
        cyc(10'h040, 3'd2, 0, 0);
        check("mid_mem_wait", ex(0,0,0,1,1,0,0,3'd0,0,4'd1));
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset", ex(0,0,0,0,0,0,0,3'd0,0,4'd0));
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(10'h040, 3'd0, 0, 1);
        check("restart_fetch", ex(1,0,0,0,1,0,0,3'd0,0,4'd0));

        fault(10'h000);
        reset_pulse();
        cyc(10'h003, 3'd0, 0, 1);
        check("fetch_003", ex(1,0,0,0,1,0,0,3'd0,0,4'd0));
        fault(10'h003);
        reset_pulse();
        cyc(10'h200, 3'd0, 0, 1);
        check("fetch_200", ex(1,0,0,0,1,0,0,3'd0,0,4'd0));
        fault(10'h200);
        reset_pulse();

        // watchdog: fetch never acknowledged
        for (int i = 0; i < 4; i++) begin
            cyc(10'h080, 3'd0, 0, 0);
            check($sformatf("wd_wait%0d", i), ex(0,0,0,0,1,0,0,3'd0,0,4'd0));
        end
        cyc(10'h080, 3'd0, 0, 0);
        check("wd_trap", ex(0,0,0,0,0,0,0,3'd0,1,4'd0));
        cyc(10'h080, 3'd0, 0, 1);
        check("wd_halt", ex(0,0,0,0,0,0,0,3'd0,1,4'd0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
